alu_arbiter: RTL

- Shares one ALU instance between NREQ independent requesters.
- Each requester posts an operand pair and a command over a valid/ready handshake.
- The block grants one request at a time in round-robin order, issues it to the ALU and waits for the ALU result.
- It then returns the result to the owning requester over a response handshake.
- A watchdog bounds the wait for the ALU.

---
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// One transaction is in flight at a time, and a watchdog bounds the wait for the ALU result.
//
// state | meaning
// IDLE  | no transaction; arbitrate among req_valid
// ISSUE | operands latched; present cmd to the ALU once alu_ready is seen
// WAIT  | command issued; wait for alu_valid or watchdog expiry
// RESP  | rsp_valid to owner; hold result until rsp_ready
module alu_arbiter #(
  parameter int              NREQ    = 4,
  parameter int              DW      = 32,
  parameter int              CW      = 4,
  parameter logic [CW-1:0]   OP_NOP  = '0,
  parameter int              TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*CW-1:0]  req_cmd,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DW-1:0]       rsp_result,
  output logic                rsp_error,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [CW-1:0]       alu_cmd,
  input  logic                alu_ready,
  input  logic                alu_valid,
  input  logic [DW-1:0]       alu_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cmd_q, cmd_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic [NREQ-1:0]   req_ready_d, rsp_valid_d;
  logic [DW-1:0]     rsp_result_d, alu_a_d, alu_b_d;
  logic              rsp_error_d;
  logic [CW-1:0]     alu_cmd_d;

  logic              grant_vld;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     cand;

  // Search last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    cand      = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cmd_d        = cmd_q;
    wd_d         = wd_q;
    req_ready_d  = '0;
    rsp_valid_d  = rsp_valid;
    rsp_result_d = rsp_result;
    rsp_error_d  = rsp_error;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_cmd_d    = OP_NOP;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready_d[grant_idx] = 1'b1;
          alu_a_d = req_a[grant_idx*DW +: DW];
          alu_b_d = req_b[grant_idx*DW +: DW];
          cmd_d   = req_cmd[grant_idx*CW +: CW];
          last_d  = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (alu_ready) begin
          alu_cmd_d = cmd_q;
          wd_d      = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the expiry cycle takes priority over the error.
        if (alu_valid) begin
          rsp_result_d        = alu_result;
          rsp_error_d         = 1'b0;
          rsp_valid_d         = '0;
          rsp_valid_d[last_q] = 1'b1;
          state_d             = RESP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          rsp_result_d        = '0;
          rsp_error_d         = 1'b1;
          rsp_valid_d         = '0;
          rsp_valid_d[last_q] = 1'b1;
          state_d             = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[last_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= IW'(NREQ - 1);
      cmd_q      <= OP_NOP;
      wd_q       <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cmd    <= OP_NOP;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cmd_q      <= cmd_d;
      wd_q       <= wd_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_result <= rsp_result_d;
      rsp_error  <= rsp_error_d;
      alu_a      <= alu_a_d;
      alu_b      <= alu_b_d;
      alu_cmd    <= alu_cmd_d;
    end
  end

endmodule
